mil_manchester_rx: RTL and testbench



---
 rtl/mil_manchester_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_mil_manchester_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mil_manchester_rx.sv
// rtl/mil_manchester_rx.sv - MIL-STD-1553 Manchester II bi-phase receive decoder
//
// Samples the differential bus pair and finds the 3-bit-time sync. It then decodes
// 16 data bits plus odd parity and pushes each good word on a request/done handshake.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   line_p/line_n asynchronous bus lines (synchronized internally)
//   push_request  word available, held until push_done is sampled
//   push_done     consumer acknowledge
//   push_type     01 = WSERV (positive-first sync), 10 = WDATA (negative-first sync)
//   push_word     decoded data word, first bit on the line is the MSB
//   err           one-cycle pulse on Manchester or parity error
//   overflow      sticky: a good word was dropped while a push was pending
//   busy          decoder is not idle

module mil_manchester_rx #(
  parameter int HALFBIT  = 50,
  parameter int SYNC_TOL = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_p,
  input  logic        line_n,
  output logic        push_request,
  input  logic        push_done,
  output logic [1:0]  push_type,
  output logic [15:0] push_word,
  output logic        err,
  output logic        overflow,
  output logic        busy
);

  // Line level encoding doubles as the push_type code of a sync with that polarity.
  localparam logic [1:0] LV_ZERO = 2'b00;
  localparam logic [1:0] LV_POS  = 2'b01;
  localparam logic [1:0] LV_NEG  = 2'b10;

  localparam logic [15:0] SYNC_MIN = 16'(3 * HALFBIT - SYNC_TOL);
  localparam logic [15:0] SYNC_MAX = 16'(3 * HALFBIT + SYNC_TOL);
  localparam logic [15:0] T_SYNC_B = 16'((3 * HALFBIT) / 2);
  localparam logic [15:0] T_FIRST0 = 16'(3 * HALFBIT + HALFBIT / 2);
  localparam logic [15:0] T_HALF   = 16'(HALFBIT);
  localparam logic [15:0] T_BIT    = 16'(2 * HALFBIT);
  localparam logic [15:0] T_END    = 16'(37 * HALFBIT);
  localparam logic [15:0] QUIET_N  = 16'(HALFBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_A,
    ST_DATA,
    ST_TAIL,
    ST_ERR_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic        p_s1, p_s2, n_s1, n_s2;
  logic [1:0]  lvl;
  logic [1:0]  sync_pol, sync_pol_nxt;
  logic [1:0]  neg_s;
  logic [15:0] cnt, cnt_nxt;
  logic [4:0]  bit_idx, bit_idx_nxt;
  logic [1:0]  first_half, first_half_nxt;
  logic [15:0] shreg, shreg_nxt;
  logic [15:0] first_pt, second_pt;
  logic        pair_ok, pair_bit;
  logic        fail;
  logic        err_nxt;
  logic        word_done;

  assign lvl       = {n_s2 & ~p_s2, p_s2 & ~n_s2};
  assign neg_s     = {sync_pol[0], sync_pol[1]};
  assign first_pt  = T_FIRST0 + 16'(bit_idx) * T_BIT;
  assign second_pt = first_pt + T_HALF;
  assign pair_ok   = ((first_half == LV_POS) && (lvl == LV_NEG)) ||
                     ((first_half == LV_NEG) && (lvl == LV_POS));
  assign pair_bit  = (first_half == LV_POS);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt      = state;
    sync_pol_nxt   = sync_pol;
    cnt_nxt        = cnt;
    bit_idx_nxt    = bit_idx;
    first_half_nxt = first_half;
    shreg_nxt      = shreg;
    fail           = 1'b0;
    err_nxt        = 1'b0;
    word_done      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (lvl != LV_ZERO) begin
          sync_pol_nxt = lvl;
          cnt_nxt      = 16'd1;
          state_nxt    = ST_SYNC_A;
        end
      end

      // cnt is the run length of the first sync half; bad syncs are dropped silently.
      ST_SYNC_A: begin
        if (lvl == sync_pol) begin
          if (cnt >= SYNC_MAX) state_nxt = ST_IDLE;
          else                 cnt_nxt   = cnt + 16'd1;
        end else if ((lvl == neg_s) && (cnt >= SYNC_MIN)) begin
          // This cycle is t=0, so the first DATA cycle is t=1.
          cnt_nxt     = 16'd1;
          bit_idx_nxt = 5'd0;
          shreg_nxt   = 16'd0;
          state_nxt   = ST_DATA;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      // cnt is t since the mid-sync transition; sampling is free-running, no resync.
      ST_DATA: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == T_SYNC_B) begin
          if (lvl != neg_s) fail = 1'b1;
        end else if (cnt == first_pt) begin
          first_half_nxt = lvl;
        end else if (cnt == second_pt) begin
          if (!pair_ok) begin
            fail = 1'b1;
          end else if (bit_idx == 5'd16) begin
            if (^{shreg, pair_bit}) begin
              word_done = 1'b1;
              state_nxt = ST_TAIL;
            end else begin
              fail = 1'b1;
            end
          end else begin
            shreg_nxt   = {shreg[14:0], pair_bit};
            bit_idx_nxt = bit_idx + 5'd1;
          end
        end
      end

      // At t=T_END the next word's sync would start; treat it like IDLE seeing a level.
      ST_TAIL: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == T_END) begin
          if (lvl == LV_ZERO) begin
            state_nxt = ST_IDLE;
          end else begin
            sync_pol_nxt = lvl;
            cnt_nxt      = 16'd1;
            state_nxt    = ST_SYNC_A;
          end
        end
      end

      // cnt counts consecutive quiet cycles before accepting a new sync.
      ST_ERR_WAIT: begin
        if (lvl == LV_ZERO) begin
          if (cnt == QUIET_N) state_nxt = ST_IDLE;
          else                cnt_nxt   = cnt + 16'd1;
        end else begin
          cnt_nxt = 16'd0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (fail) begin
      err_nxt   = 1'b1;
      cnt_nxt   = 16'd0;
      state_nxt = ST_ERR_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_s1       <= 1'b0;
      p_s2       <= 1'b0;
      n_s1       <= 1'b0;
      n_s2       <= 1'b0;
      state      <= ST_IDLE;
      sync_pol   <= LV_ZERO;
      cnt        <= 16'd0;
      bit_idx    <= 5'd0;
      first_half <= LV_ZERO;
      shreg      <= 16'd0;
      err        <= 1'b0;
    end else begin
      p_s1       <= line_p;
      p_s2       <= p_s1;
      n_s1       <= line_n;
      n_s2       <= n_s1;
      state      <= state_nxt;
      sync_pol   <= sync_pol_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      first_half <= first_half_nxt;
      shreg      <= shreg_nxt;
      err        <= err_nxt;
    end
  end

  // A done sampled in the same cycle as a new word frees the slot for that word.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_request <= 1'b0;
      push_type    <= 2'b00;
      push_word    <= 16'd0;
      overflow     <= 1'b0;
    end else if (word_done && (!push_request || push_done)) begin
      push_request <= 1'b1;
      push_type    <= sync_pol;
      push_word    <= shreg;
    end else begin
      if (push_request && push_done) push_request <= 1'b0;
      if (word_done)                 overflow     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mil_manchester_rx.sv
// tb/tb_mil_manchester_rx.sv - scoreboard bench for mil_manchester_rx
module tb_mil_manchester_rx;

  localparam int HB = 50;
  localparam logic [1:0] LP = 2'b01;
  localparam logic [1:0] LN = 2'b10;
  localparam logic [1:0] L0 = 2'b00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_p = 1'b0;
  logic        line_n = 1'b0;
  logic        push_request;
  logic        push_done = 1'b0;
  logic [1:0]  push_type;
  logic [15:0] push_word;
  logic        err;
  logic        overflow;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_count = 0;
  logic        err_prev = 1'b0;
  bit          auto_ack = 1'b1;
  bit          pending_seen = 1'b0;
  logic [17:0] exp_q[$];
  int          rise_q[$];

  mil_manchester_rx #(.HALFBIT(HB), .SYNC_TOL(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_p       (line_p),
    .line_n       (line_n),
    .push_request (push_request),
    .push_done    (push_done),
    .push_type    (push_type),
    .push_word    (push_word),
    .err          (err),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"},      32'(push_request), 0);
    chk({tag, "_type"},     32'(push_type),    0);
    chk({tag, "_word"},     32'(push_word),    0);
    chk({tag, "_err"},      32'(err),          0);
    chk({tag, "_overflow"}, 32'(overflow),     0);
    chk({tag, "_busy"},     32'(busy),         0);
  endtask

  task automatic drive_half(input logic [1:0] lv, input bit do_rst);
    line_p = lv[0];
    line_n = lv[1];
    if (do_rst) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_outputs_zero("midword_rst");
      repeat (HB - 1) @(negedge clk);
    end else begin
      repeat (HB) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [1:0] pol, input logic [15:0] data,
                           input logic par, input int rst_half);
    logic [1:0] halves[40];
    logic [1:0] npol;
    npol = {pol[0], pol[1]};
    for (int i = 0; i < 3; i++) begin
      halves[i]     = pol;
      halves[i + 3] = npol;
    end
    for (int i = 0; i < 16; i++) begin
      halves[6 + 2 * i] = data[15 - i] ? LP : LN;
      halves[7 + 2 * i] = data[15 - i] ? LN : LP;
    end
    halves[38] = par ? LP : LN;
    halves[39] = par ? LN : LP;
    for (int i = 0; i < 40; i++) drive_half(halves[i], i == rst_half);
  endtask

  task automatic gap(input int n);
    line_p = 1'b0;
    line_n = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!push_request && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, 32'(push_request), 1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!push_done && n < 100);
    chk({tag, "_ack_seen"}, 32'(push_done), 1);
    @(negedge clk);
    chk({tag, "_req_drop"}, 32'(push_request), 0);
  endtask

  // Consumer and scoreboard side: compare each new word once, ack when allowed.
  always @(negedge clk) begin
    if (err) begin
      chk("err_one_cycle", 32'(err_prev), 0);
      if (!err_prev) err_count++;
    end
    err_prev = err;

    if (push_done) begin
      push_done    = 1'b0;
      pending_seen = 1'b0;
    end else if (push_request) begin
      if (!pending_seen) begin
        logic [17:0] e;
        chk("push_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("push_type", 32'(push_type), 32'(e[17:16]));
          chk("push_word", 32'(push_word), 32'(e[15:0]));
        end
        rise_q.push_back(cyc);
        pending_seen = 1'b1;
      end
      if (auto_ack) push_done = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    gap(20);

    // Positive-first 1111, held request until a manual done.
    auto_ack = 1'b0;
    exp_q.push_back({LP, 16'h1111});
    send_word(LP, 16'h1111, ~^16'h1111, -1);
    gap(0);
    wait_req("t1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_req_hold", 32'(push_request), 1);
    end
    chk("t1_no_err", 32'(err_count), 0);
    auto_ack = 1'b1;
    wait_ack("t1");
    chk("t1_word_after_drop", 32'(push_word), 32'h1111);
    chk("t1_type_after_drop", 32'(push_type), 32'(LP));
    gap(200);

    // Back-to-back negative-first words, no gap.
    rise_q.delete();
    exp_q.push_back({LN, 16'hBBBB});
    exp_q.push_back({LN, 16'hAAAA});
    send_word(LN, 16'hBBBB, ~^16'hBBBB, -1);
    send_word(LN, 16'hAAAA, ~^16'hAAAA, -1);
    gap(200);
    chk("t2_push_count", 32'(rise_q.size()), 2);
    if (rise_q.size() == 2) chk("t2_spacing", 32'(rise_q[1] - rise_q[0]), 2000);

    // Bad parity, then a good word after idle.
    e0 = err_count;
    send_word(LP, 16'h1111, ^16'h1111, -1);
    gap(200);
    chk("t3_err_pulse", 32'(err_count), 32'(e0 + 1));
    chk("t3_no_req", 32'(push_request), 0);
    exp_q.push_back({LP, 16'h1234});
    send_word(LP, 16'h1234, ~^16'h1234, -1);
    gap(200);
    chk("t3_recovered", 32'(exp_q.size()), 0);

    // Short first sync half: silently ignored.
    e0 = err_count;
    line_p = 1'b1; line_n = 1'b0;
    repeat (2 * HB) @(negedge clk);
    line_p = 1'b0; line_n = 1'b1;
    repeat (3 * HB) @(negedge clk);
    gap(200);
    chk("t4_no_err", 32'(err_count), 32'(e0));
    chk("t4_not_busy", 32'(busy), 0);
    chk("t4_no_req", 32'(push_request), 0);

    // Overflow while a word is pending.
    auto_ack = 1'b0;
    exp_q.push_back({LP, 16'h2222});
    send_word(LP, 16'h2222, ~^16'h2222, -1);
    gap(100);
    send_word(LP, 16'h3333, ~^16'h3333, -1);
    gap(100);
    chk("t5_overflow", 32'(overflow), 1);
    chk("t5_word_kept", 32'(push_word), 32'h2222);
    chk("t5_req_held", 32'(push_request), 1);
    auto_ack = 1'b1;
    wait_ack("t5");
    chk("t5_overflow_sticky", 32'(overflow), 1);
    gap(100);

    // Reset pulse during bit 8, then a clean word.
    e0 = err_count;
    send_word(LP, 16'h5555, ~^16'h5555, 22);
    gap(200);
    chk("t6_no_err", 32'(err_count), 32'(e0));
    chk("t6_no_req", 32'(push_request), 0);
    exp_q.push_back({LP, 16'h5555});
    send_word(LP, 16'h5555, ~^16'h5555, -1);
    gap(200);

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_err_total", 32'(err_count), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
